// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RISC-V sequencer: PC, instruction register, FETCH/DECODE/EXECUTE/MEM/WB FSM, retire counter, trap.
// Optional macro RISCV_SEQ_TIMEOUT_EN adds per-access wait timeouts (trap causes 10/11).
module riscv_mc_sequencer #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    input  logic            is_r_type_i,
    input  logic            is_i_type_i,
    input  logic            is_s_type_i,
    input  logic            is_b_type_i,
    input  logic            is_u_type_i,
    input  logic            is_j_type_i,
    input  logic            mem_rd_i,
    input  logic            mem_wr_i,
    input  logic            rf_en_i,
    input  logic [XLEN-1:0] pc_next_i,
    output logic [XLEN-1:0] pc_o,
    output logic            alu_en_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    input  logic            dmem_rvalid_i,
    output logic            rf_we_o,
    output logic [31:0]     instret_o,
    output logic            trap_o,
    output logic [1:0]      trap_cause_o
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t state;
    logic   cap_rd;
    logic   cap_wr;
    logic   cap_rf;
    logic   any_type;

    assign imem_addr_o = pc_o;
    assign any_type    = |{is_r_type_i, is_i_type_i, is_s_type_i,
                           is_b_type_i, is_u_type_i, is_j_type_i};

`ifdef RISCV_SEQ_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Strobes are registered alongside the state transition, so each one
    // is a pure function of the current state and the captured control bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_FETCH;
            pc_o         <= RESET_PC;
            instr_o      <= '0;
            instret_o    <= '0;
            cap_rd       <= 1'b0;
            cap_wr       <= 1'b0;
            cap_rf       <= 1'b0;
            imem_req_o   <= 1'b1;
            alu_en_o     <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            rf_we_o      <= 1'b0;
            trap_o       <= 1'b0;
            trap_cause_o <= 2'b00;
`ifdef RISCV_SEQ_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_rvalid_i) begin
                        instr_o    <= imem_rdata_i;
                        imem_req_o <= 1'b0;
                        state      <= S_DECODE;
                    end
`ifdef RISCV_SEQ_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        imem_req_o   <= 1'b0;
                        trap_o       <= 1'b1;
                        trap_cause_o <= 2'b10;
                        state        <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    if (!any_type) begin
                        trap_o       <= 1'b1;
                        trap_cause_o <= 2'b01;
                        state        <= S_TRAP;
                    end else begin
                        cap_rd   <= mem_rd_i;
                        cap_wr   <= mem_wr_i;
                        cap_rf   <= rf_en_i;
                        alu_en_o <= 1'b1;
                        state    <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    alu_en_o <= 1'b0;
                    if (cap_rd || cap_wr) begin
                        dmem_req_o <= 1'b1;
                        dmem_we_o  <= cap_wr;
                        state      <= S_MEM;
`ifdef RISCV_SEQ_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end else begin
                        rf_we_o <= cap_rf;
                        state   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_rvalid_i) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        rf_we_o    <= cap_rf;
                        state      <= S_WB;
                    end
`ifdef RISCV_SEQ_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        trap_o       <= 1'b1;
                        trap_cause_o <= 2'b11;
                        state        <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_WB: begin
                    rf_we_o    <= 1'b0;
                    pc_o       <= pc_next_i;
                    instret_o  <= instret_o + 32'd1;
                    imem_req_o <= 1'b1;
                    state      <= S_FETCH;
`ifdef RISCV_SEQ_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    imem_req_o <= 1'b0;
                    alu_en_o   <= 1'b0;
                    dmem_req_o <= 1'b0;
                    dmem_we_o  <= 1'b0;
                    rf_we_o    <= 1'b0;
                    trap_o     <= 1'b1;
                    state      <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Randomized bench for riscv_mc_sequencer: per-instruction cycle/strobe budgets derived from the
// sequencing rules are compared against observed behaviour with immediate assertions.
`define CHK(TAG, OBS, EXP) \
    begin \
        n_assert++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_riscv_mc_sequencer;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i = 1'b0;
    logic [31:0]     imem_rdata_i = '0;
    logic [31:0]     instr_o;
    logic [5:0]      flags = '0;
    logic            mem_rd_i = 1'b0;
    logic            mem_wr_i = 1'b0;
    logic            rf_en_i = 1'b0;
    logic [XLEN-1:0] pc_next_i = '0;
    logic [XLEN-1:0] pc_o;
    logic            alu_en_o;
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic            dmem_rvalid_i = 1'b0;
    logic            rf_we_o;
    logic [31:0]     instret_o;
    logic            trap_o;
    logic [1:0]      trap_cause_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_instret;
    logic [31:0] exp_pc;

    riscv_mc_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o),
        .is_r_type_i(flags[0]), .is_i_type_i(flags[1]), .is_s_type_i(flags[2]),
        .is_b_type_i(flags[3]), .is_u_type_i(flags[4]), .is_j_type_i(flags[5]),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .rf_en_i(rf_en_i),
        .pc_next_i(pc_next_i), .pc_o(pc_o), .alu_en_o(alu_en_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_rvalid_i(dmem_rvalid_i),
        .rf_we_o(rf_we_o), .instret_o(instret_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        imem_rvalid_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        flags         = '0;
        repeat (2) step();
        reset_n     = 1'b1;
        exp_pc      = RESET_PC;
        exp_instret = '0;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. Starts and ends at the first FETCH cycle of an instruction.
    task automatic run_instr(input int iw, input int dw, input int kind, input logic rf,
                             input logic [5:0] fl, input logic [31:0] pcn, input bit spurious);
        int   cyc = 0, nreq = 0, ndreq = 0, nalu = 0, nrf = 0, we_bad = 0;
        int   alu_cyc = -1, rf_cyc = -1, exp_cyc;
        bit   fetched = 0, done = 0;
        logic [31:0] word = '0;
        logic is_mem = (kind != 0);

        `CHK("imem_addr", imem_addr_o, exp_pc)
        flags     = fl;
        mem_rd_i  = (kind == 1);
        mem_wr_i  = (kind == 2);
        rf_en_i   = rf;
        pc_next_i = pcn;
        while (!done && cyc < 200) begin
            imem_rdata_i = $urandom;
            if (imem_req_o) begin
                nreq++;
                imem_rvalid_i = (nreq == iw + 1);
                if (imem_rvalid_i) begin
                    word    = imem_rdata_i;
                    fetched = 1;
                end
            end else begin
                imem_rvalid_i = spurious ? 1'($urandom) : 1'b0;
            end
            if (dmem_req_o) begin
                ndreq++;
                if (dmem_we_o !== (kind == 2)) we_bad++;
                dmem_rvalid_i = (ndreq == dw + 1);
            end else begin
                dmem_rvalid_i = spurious ? 1'($urandom) : 1'b0;
            end
            if (alu_en_o) begin
                nalu++;
                if (alu_cyc < 0) alu_cyc = cyc;
            end
            if (rf_we_o) begin
                nrf++;
                if (rf_cyc < 0) rf_cyc = cyc;
            end
            step();
            cyc++;
            if (fetched && imem_req_o) done = 1;
        end
        imem_rvalid_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        exp_cyc     = (iw + 1) + 1 + 1 + (is_mem ? dw + 1 : 0) + 1;
        exp_pc      = pcn;
        exp_instret = exp_instret + 32'd1;
        `CHK("instr_cycles", cyc, exp_cyc)
        `CHK("imem_req_cycles", nreq, iw + 1)
        `CHK("alu_en_count", nalu, 1)
        `CHK("alu_en_cycle", alu_cyc, iw + 2)
        `CHK("dmem_req_cycles", ndreq, is_mem ? dw + 1 : 0)
        `CHK("dmem_we_bad", we_bad, 0)
        `CHK("rf_we_count", nrf, rf ? 1 : 0)
        if (rf) `CHK("rf_we_cycle", rf_cyc, exp_cyc - 1)
        `CHK("instr_reg", instr_o, word)
        `CHK("pc_after", pc_o, exp_pc)
        `CHK("instret_after", instret_o, exp_instret)
        `CHK("trap_clear", trap_o, 1'b0)
    endtask

    initial begin
        int nreq, nbad;
        logic [31:0] pc_hold;

        // Reset behaviour
        do_reset();
        `CHK("rst_pc", pc_o, RESET_PC)
        `CHK("rst_instret", instret_o, 32'd0)
        `CHK("rst_imem_req", imem_req_o, 1'b1)
        `CHK("rst_trap", trap_o, 1'b0)
        `CHK("rst_cause", trap_cause_o, 2'b00)
        `CHK("rst_instr", instr_o, 32'd0)
        `CHK("rst_strobes", {alu_en_o, dmem_req_o, dmem_we_o, rf_we_o}, 4'b0000)

        // ADD, zero-wait fetch, pc_next = 4
        run_instr(0, 0, 0, 1'b1, 6'b000001, 32'd4, 0);
        // LW, imem 2-wait, dmem 3-wait
        run_instr(2, 3, 1, 1'b1, 6'b000010, 32'd8, 0);
        // SW without register write
        run_instr(0, 1, 2, 1'b0, 6'b000100, 32'd12, 0);

        // Random mix, with spurious acknowledges outside their states
        for (int i = 0; i < 25; i++) begin
            logic [5:0] fl;
            fl = 6'($urandom_range(1, 63));
            run_instr($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2),
                      1'($urandom), fl, {$urandom} & 32'hFFFF_FFFC, 1);
        end

        // Retire counter wrap: preload while stalled in FETCH
        force dut.instret_o = 32'hFFFF_FFFF;
        step();
        release dut.instret_o;
        step();
        exp_instret = 32'hFFFF_FFFF;
        run_instr(1, 0, 0, 1'b1, 6'b100000, 32'h40, 1);
        `CHK("instret_wrap", instret_o, 32'd0)

        // Illegal instruction: no class flag in DECODE
        flags     = '0;
        mem_rd_i  = 1'b1;
        rf_en_i   = 1'b1;
        pc_next_i = 32'h1234;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hFFFF_FFFF;
        step();
        imem_rvalid_i = 1'b0;
        `CHK("illegal_decode_trap", trap_o, 1'b0)
        step();
        `CHK("illegal_trap", trap_o, 1'b1)
        `CHK("illegal_cause", trap_cause_o, 2'b01)
        pc_hold = pc_o;
        `CHK("illegal_pc", pc_hold, exp_pc)
        nreq = 0;
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_rvalid_i = 1'($urandom);
            dmem_rvalid_i = 1'($urandom);
            if (imem_req_o) nreq++;
            if (alu_en_o || dmem_req_o || rf_we_o || pc_o !== pc_hold || trap_o !== 1'b1) nbad++;
            step();
        end
        `CHK("trap_imem_req", nreq, 0)
        `CHK("trap_frozen", nbad, 0)
        `CHK("trap_instret", instret_o, exp_instret)
        do_reset();
        `CHK("trap_rst_pc", pc_o, RESET_PC)
        `CHK("trap_rst_flag", trap_o, 1'b0)
        `CHK("trap_rst_cause", trap_cause_o, 2'b00)

        // Fetch with no acknowledge
        nreq = 0;
`ifdef RISCV_SEQ_TIMEOUT_EN
        for (int i = 0; i < 40 && !trap_o; i++) begin
            if (imem_req_o) nreq++;
            step();
        end
        `CHK("timeout_req_cycles", nreq, 16)
        `CHK("timeout_trap", trap_o, 1'b1)
        `CHK("timeout_cause", trap_cause_o, 2'b10)
`else
        nbad = 0;
        for (int i = 0; i < 100; i++) begin
            if (imem_req_o) nreq++;
            if (trap_o) nbad++;
            step();
        end
        `CHK("stall_req_cycles", nreq, 100)
        `CHK("stall_no_trap", nbad, 0)
        `CHK("stall_cause", trap_cause_o, 2'b00)
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
